// File: rtl/seq_pkg.sv
// Shared constants and types for the 3-bit counter sequence checker:
// reference sequence table, FSM state enum and pair-lookup result payload.
package seq_pkg;

   localparam int unsigned SEQ_LEN = 8;
   localparam int unsigned DATA_W  = 3;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [1:0] {
      H0   = 2'd0,
      H1   = 2'd1,
      LOCK = 2'd2
   } state_t;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
   } pair_hit_t;

   localparam logic [DATA_W-1:0] SEQ [SEQ_LEN] = '{
      3'd2, 3'd3, 3'd5, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6
   };

   function automatic logic [DATA_W-1:0] seq_at(input logic [IDX_W-1:0] idx);
      return SEQ[idx];
   endfunction

endpackage

// File: rtl/seq_pair_lookup.sv
// Combinational lookup of a (prev, cur) sample pair among the consecutive
// pairs of the reference sequence; index is the position of cur.
module seq_pair_lookup
   import seq_pkg::*;
(
   input  logic [DATA_W-1:0] i_prev,
   input  logic [DATA_W-1:0] i_cur,
   output pair_hit_t         o_res_c
);

   // Every consecutive pair is unique, so at most one index can hit.
   always_comb begin
      o_res_c = '0;
      for (int unsigned i = 0; i < SEQ_LEN; i++) begin
         if (i_prev == seq_at(IDX_W'(i + SEQ_LEN - 1)) &&
             i_cur  == seq_at(IDX_W'(i))) begin
            o_res_c.hit = 1'b1;
            o_res_c.idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/seq_checker.sv
// Alignment checker for a free-running 2,3,5,2,0,3,4,6 counter stream.
// Optional saturating mismatch counter enabled by SEQ_CHECKER_ERR_CNT_EN.
module seq_checker
   import seq_pkg::*;
#(
   parameter int unsigned ERR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_data,
   output logic              locked,
   output logic [IDX_W-1:0]  pos,
   output logic              err,
   output logic              wrap
`ifdef SEQ_CHECKER_ERR_CNT_EN
  ,output logic [ERR_W-1:0]  err_cnt
`endif
);

   if (ERR_W == 0) begin : g_err_w_check
      $error("seq_checker: ERR_W must be at least 1");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_prev;
   logic [DATA_W-1:0] w_prev_nxt;
   logic [IDX_W-1:0]  r_pos;
   logic [IDX_W-1:0]  w_pos_nxt;
   logic [IDX_W-1:0]  w_pos_inc;
   logic              r_err;
   logic              w_err_nxt;
   logic              r_wrap;
   logic              w_wrap_nxt;
   logic              r_locked;
   pair_hit_t         w_pair;

   seq_pair_lookup u_lookup (
      .i_prev  (r_prev),
      .i_cur   (in_data),
      .o_res_c (w_pair)
   );

   assign w_pos_inc = IDX_W'(r_pos + IDX_W'(1));

   // State and flag registers; locked mirrors the next state so it drops with err.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= H0;
         r_prev   <= '0;
         r_pos    <= '0;
         r_err    <= 1'b0;
         r_wrap   <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_prev   <= w_prev_nxt;
         r_pos    <= w_pos_nxt;
         r_err    <= w_err_nxt;
         r_wrap   <= w_wrap_nxt;
         r_locked <= (w_state_nxt == LOCK);
      end
   end

   // Next-state and flag decode; clr outranks en.
   always_comb begin
      w_state_nxt = r_state;
      w_prev_nxt  = r_prev;
      w_pos_nxt   = r_pos;
      w_err_nxt   = 1'b0;
      w_wrap_nxt  = 1'b0;
      if (clr) begin
         w_state_nxt = H0;
      end else if (en) begin
         case (r_state)
            H0: begin
               w_prev_nxt  = in_data;
               w_state_nxt = H1;
            end
            H1: begin
               if (w_pair.hit) begin
                  w_pos_nxt   = w_pair.idx;
                  w_state_nxt = LOCK;
               end else begin
                  w_prev_nxt = in_data;
               end
            end
            LOCK: begin
               if (in_data == seq_at(w_pos_inc)) begin
                  w_pos_nxt  = w_pos_inc;
                  w_wrap_nxt = (w_pos_inc == IDX_W'(SEQ_LEN - 1));
               end else begin
                  w_err_nxt   = 1'b1;
                  w_prev_nxt  = in_data;
                  w_state_nxt = H1;
               end
            end
            default: w_state_nxt = H0;
         endcase
      end
   end

   assign locked = r_locked;
   assign pos    = r_pos;
   assign err    = r_err;
   assign wrap   = r_wrap;

`ifdef SEQ_CHECKER_ERR_CNT_EN
   logic [ERR_W-1:0] r_err_cnt;

   // Saturating count of err pulses; untouched by clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_cnt <= '0;
      end else if (w_err_nxt && (r_err_cnt != {ERR_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
   end

   assign err_cnt = r_err_cnt;
`endif

endmodule
